// File: rtl/rf_multiport_seq_if.sv
// Bus bundle for rf_multiport_seq: read ports, general and SP write paths,
// and the register-list sequencer controls/status.
`timescale 1ns/1ps

interface rf_multiport_seq_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int RD_PORTS = 2
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [RD_PORTS*IDX_W-1:0]  rd_sel_i;
  logic [RD_PORTS*DATA_W-1:0] rd_data_o;

  logic                       wr_en_i;
  logic [IDX_W-1:0]           wr_sel_i;
  logic [DATA_W-1:0]          wr_data_i;

  logic                       sp_wr_en_i;
  logic [DATA_W-1:0]          sp_data_i;

  logic                       list_start_i;
  logic [NUM_REGS-1:0]        list_mask_i;
  logic                       list_desc_i;
  logic                       list_busy_o;
  logic [IDX_W-1:0]           list_sel_o;
  logic                       list_last_o;
  logic [IDX_W:0]             list_count_o;

  // Decode stage side.
  modport master (
    output rd_sel_i, wr_en_i, wr_sel_i, wr_data_i, sp_wr_en_i, sp_data_i,
           list_start_i, list_mask_i, list_desc_i,
    input  rd_data_o, list_busy_o, list_sel_o, list_last_o, list_count_o
  );

  // Register file side.
  modport slave (
    input  rd_sel_i, wr_en_i, wr_sel_i, wr_data_i, sp_wr_en_i, sp_data_i,
           list_start_i, list_mask_i, list_desc_i,
    output rd_data_o, list_busy_o, list_sel_o, list_last_o, list_count_o
  );
endinterface

// File: rtl/rf_multiport_seq.sv
// Multi-port register file with SP write path, PC pseudo-register and a
// PUSH/POP register-list sequencer. Define RF_BYPASS_EN for write-to-read forwarding.
`timescale 1ns/1ps

module rf_multiport_seq #(
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 16,
  parameter int                  RD_PORTS = 2,
  parameter int                  SP_IDX   = 13,
  parameter int                  PC_IDX   = 15,
  parameter logic [DATA_W-1:0]   SP_RESET = 32'h0000_0400
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic [DATA_W-1:0]      pc_i,
  rf_multiport_seq_if.slave      bus
);

  localparam int IDX_W       = $clog2(NUM_REGS);
  // Storage is padded to a power of two so any select addresses a real entry.
  localparam int NUM_ENTRIES = 2 ** IDX_W;

  localparam logic [IDX_W-1:0] SP_SEL = IDX_W'(SP_IDX);
  localparam logic [IDX_W-1:0] PC_SEL = IDX_W'(PC_IDX);

  typedef enum logic {
    ST_IDLE,
    ST_WALK
  } seq_state_e;

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_ENTRIES];

  // NOTE: this array is reset because the architecture requires known register
  // contents (SP in particular) after reset; a plain RAM would not be.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      // The general write port is issued last so it overrides the SP path.
      if (bus.sp_wr_en_i) begin
        regs_q[SP_SEL] <= bus.sp_data_i;
      end
      if (bus.wr_en_i && (bus.wr_sel_i != PC_SEL)) begin
        regs_q[bus.wr_sel_i] <= bus.wr_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [IDX_W-1:0]  sel;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    assign sel = bus.rd_sel_i[k*IDX_W +: IDX_W];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
      rd_d = regs_q[sel];
`ifdef RF_BYPASS_EN
      if (bus.sp_wr_en_i && (sel == SP_SEL)) begin
        rd_d = bus.sp_data_i;
      end
      if (bus.wr_en_i && (bus.wr_sel_i == sel)) begin
        rd_d = bus.wr_data_i;
      end
`endif
      if (sel == PC_SEL) begin
        rd_d = pc_i;
      end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_q <= '0;
      end else if (!stall_i) begin
        rd_q <= rd_d;
      end
    end

    assign bus.rd_data_o[k*DATA_W +: DATA_W] = rd_q;
  end

  // ---------------------------------------------------------------------------
  // Register-list sequencer
  // ---------------------------------------------------------------------------
  seq_state_e          state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic                desc_q, desc_d;
  logic [IDX_W:0]      count_q, count_d;

  logic [IDX_W-1:0]    sel_lo;
  logic [IDX_W-1:0]    sel_hi;
  logic [IDX_W-1:0]    cur_sel;
  logic                one_left;

  function automatic logic [IDX_W:0] popcount(input logic [NUM_REGS-1:0] m);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + (IDX_W+1)'(m[i]);
    end
    return c;
  endfunction

  // Priority encoders over the remaining mask; later hits overwrite earlier ones.
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_lo = IDX_W'(i);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (mask_q[i]) sel_hi = IDX_W'(i);
    end
  end

  assign cur_sel  = desc_q ? sel_hi : sel_lo;
  assign one_left = (mask_q != '0) &&
                    ((mask_q & (mask_q - NUM_REGS'(1))) == '0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    desc_d  = desc_q;
    count_d = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.list_start_i && !stall_i) begin
          count_d = popcount(bus.list_mask_i);
          if (bus.list_mask_i != '0) begin
            mask_d  = bus.list_mask_i;
            desc_d  = bus.list_desc_i;
            state_d = ST_WALK;
          end
        end
      end
      ST_WALK: begin
        if (!stall_i) begin
          mask_d[cur_sel] = 1'b0;
          if (one_left) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      desc_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      desc_q  <= desc_d;
      count_q <= count_d;
    end
  end

  assign bus.list_busy_o  = (state_q == ST_WALK);
  assign bus.list_sel_o   = cur_sel;
  assign bus.list_last_o  = (state_q == ST_WALK) && one_left;
  assign bus.list_count_o = count_q;

endmodule
